// File: rtl/vram_pkg.sv
// Shared types and defaults for the frame-buffer arbiter: tag encodings, slot states, sizes.
package vram_pkg;

  localparam int AW_DEF         = 15;
  localparam int DW_DEF         = 12;
  localparam int STARVE_MAX_DEF = 8;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Core writes return nothing, so they ride the pipe as empty slots.
  function automatic tag_e cpu_tag(input logic we);
    return we ? TAG_NONE : TAG_CPU;
  endfunction

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Read-return router: tags follow each RAM access for two cycles, then steer MEM_RDATA
// to the video or core return port as a registered one-cycle pulse.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  tag_e          issue_tag_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          vid_rvalid_o,
  output logic [DW-1:0] vid_rdata_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o
);

  tag_e          tag0_q, tag1_q;
  logic          vid_rvalid_q, vid_rvalid_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] vid_rdata_q, vid_rdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;

  // tag1_q lines up with the cycle in which the RAM presents the read data.
  always_comb begin
    vid_rvalid_d = (tag1_q == TAG_VID);
    cpu_rvalid_d = (tag1_q == TAG_CPU);
    vid_rdata_d  = vid_rvalid_d ? mem_rdata_i : vid_rdata_q;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata_i : cpu_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag0_q       <= TAG_NONE;
      tag1_q       <= TAG_NONE;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      tag0_q       <= issue_tag_i;
      tag1_q       <= tag0_q;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign vid_rvalid_o = vid_rvalid_q;
  assign vid_rdata_o  = vid_rdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: video reads have priority, core fills idle slots.
// Build option VRAM_ANTISTARVE_EN adds a core wait counter and a 1-deep video skid register.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
`ifdef VRAM_ANTISTARVE_EN
  ,
  parameter int STARVE_MAX = STARVE_MAX_DEF
`endif
) (
  input  logic          CLK_50M,
  input  logic          RST,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_ADDR,
  output logic          VID_RVALID,
  output logic [DW-1:0] VID_RDATA,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  output logic          CPU_RVALID,
  output logic [DW-1:0] CPU_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          VID_OVERRUN
);

  state_e        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  tag_e          issue_tag;
  logic          take_vid, take_cpu;
  logic [AW-1:0] vid_addr_sel;
  logic          cpu_ack;

  // state_q names the slot currently driven onto MEM_*, so the ack is aligned with it.
  // A request sampled during the ack cycle is treated as the core's next request.
  assign cpu_ack = (state_q == ST_CPU) || (state_q == ST_HOLD);

`ifdef VRAM_ANTISTARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic [AW-1:0] skid_addr_q, skid_addr_d;
  logic          overrun_q, overrun_d;
  logic          starve;

  assign starve = CPU_REQ && (int'(wait_q) >= STARVE_MAX);

  always_comb begin
    wait_d = wait_q;
    if (cpu_ack) begin
      wait_d = '0;
    end else if (CPU_REQ && (int'(wait_q) < STARVE_MAX)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = ST_IDLE;
    take_vid     = 1'b0;
    take_cpu     = 1'b0;
    vid_addr_sel = VID_ADDR;
    skid_addr_d  = skid_addr_q;
    overrun_d    = overrun_q;
    if (state_q == ST_HOLD) begin
      // Skid drains unconditionally; a new request now has nowhere to go.
      state_d      = ST_VID;
      take_vid     = 1'b1;
      vid_addr_sel = skid_addr_q;
      if (VID_REQ) begin
        overrun_d = 1'b1;
      end
    end else if (VID_REQ && starve) begin
      state_d     = ST_HOLD;
      take_cpu    = 1'b1;
      skid_addr_d = VID_ADDR;
    end else if (VID_REQ) begin
      state_d  = ST_VID;
      take_vid = 1'b1;
    end else if (CPU_REQ) begin
      state_d  = ST_CPU;
      take_cpu = 1'b1;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      wait_q      <= '0;
      skid_addr_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      skid_addr_q <= skid_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign VID_OVERRUN = overrun_q;
`else
  always_comb begin
    state_d      = ST_IDLE;
    take_vid     = VID_REQ;
    take_cpu     = !VID_REQ && CPU_REQ;
    vid_addr_sel = VID_ADDR;
    if (take_vid) begin
      state_d = ST_VID;
    end else if (take_cpu) begin
      state_d = ST_CPU;
    end
  end

  assign VID_OVERRUN = 1'b0;
`endif

  // Idle slots keep the last address so the RAM sees no spurious address toggles.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    issue_tag   = TAG_NONE;
    if (take_vid) begin
      mem_addr_d = vid_addr_sel;
      issue_tag  = TAG_VID;
    end else if (take_cpu) begin
      mem_addr_d  = CPU_ADDR;
      mem_we_d    = CPU_WE;
      mem_wdata_d = CPU_WDATA;
      issue_tag   = cpu_tag(CPU_WE);
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  vram_rd_tag_pipe #(
    .DW(DW)
  ) u_tag_pipe (
    .clk_i       (CLK_50M),
    .rst_i       (RST),
    .issue_tag_i (issue_tag),
    .mem_rdata_i (MEM_RDATA),
    .vid_rvalid_o(VID_RVALID),
    .vid_rdata_o (VID_RDATA),
    .cpu_rvalid_o(CPU_RVALID),
    .cpu_rdata_o (CPU_RDATA)
  );

  assign CPU_ACK   = cpu_ack;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: 1-cycle synchronous RAM model, directed scenarios and randomized traffic
// checked against a per-cycle arbitration/memory reference model.
module tb_vram_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int DEPTH = 19200;

  logic          CLK_50M = 1'b0;
  logic          RST;
  logic          VID_REQ;
  logic [AW-1:0] VID_ADDR;
  logic          VID_RVALID;
  logic [DW-1:0] VID_RDATA;
  logic          CPU_REQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_ACK;
  logic          CPU_RVALID;
  logic [DW-1:0] CPU_RDATA;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WE;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic          VID_OVERRUN;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLK_50M = ~CLK_50M;

  vram_arbiter #(
    .AW(AW),
    .DW(DW)
`ifdef VRAM_ANTISTARVE_EN
    ,
    .STARVE_MAX(2)
`endif
  ) dut (
    .CLK_50M    (CLK_50M),
    .RST        (RST),
    .VID_REQ    (VID_REQ),
    .VID_ADDR   (VID_ADDR),
    .VID_RVALID (VID_RVALID),
    .VID_RDATA  (VID_RDATA),
    .CPU_REQ    (CPU_REQ),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_ACK    (CPU_ACK),
    .CPU_RVALID (CPU_RVALID),
    .CPU_RDATA  (CPU_RDATA),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WE     (MEM_WE),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA),
    .VID_OVERRUN(VID_OVERRUN)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    logic [DW-1:0] v;
    if (a == 16) v = 12'hABC;
    else v = DW'(a * 37 + 5);
    return v;
  endfunction

  // RAM device: contents start at init_val until written; read-before-write on the same edge.
  logic [DW-1:0] ram    [0:DEPTH-1];
  bit            ram_wr [0:DEPTH-1];
  always @(posedge CLK_50M) begin
    if (int'(MEM_ADDR) < DEPTH) begin
      MEM_RDATA <= ram_wr[MEM_ADDR] ? ram[MEM_ADDR] : init_val(int'(MEM_ADDR));
      if (MEM_WE) begin
        ram[MEM_ADDR]    <= MEM_WDATA;
        ram_wr[MEM_ADDR] <= 1'b1;
      end
    end else begin
      MEM_RDATA <= '0;
    end
  end

  // Reference view of memory contents in issue order.
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  task automatic step();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic idle_inputs();
    VID_REQ   = 1'b0;
    CPU_REQ   = 1'b0;
    CPU_WE    = 1'b0;
    VID_ADDR  = '0;
    CPU_ADDR  = '0;
    CPU_WDATA = '0;
  endtask

  task automatic test_reset();
    logic [63:0] all_out;
    RST = 1'b1;
    idle_inputs();
    repeat (3) step();
    all_out = {VID_RVALID, VID_RDATA, CPU_ACK, CPU_RVALID, CPU_RDATA, MEM_ADDR, MEM_WE, MEM_WDATA, VID_OVERRUN};
    n_checks++;
    if (all_out !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    RST = 1'b0;
    repeat (2) step();
    all_out = {VID_RVALID, VID_RDATA, CPU_ACK, CPU_RVALID, CPU_RDATA, MEM_ADDR, MEM_WE, MEM_WDATA, VID_OVERRUN};
    n_checks++;
    if (all_out !== 64'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h want 0", all_out);
    end
  endtask

  task automatic test_vid_read();
    repeat (3) step();
    VID_REQ  = 1'b1;
    VID_ADDR = 15'h0010;
    step();
    VID_REQ = 1'b0;
    n_checks++;
    if (MEM_ADDR !== 15'h0010 || MEM_WE !== 1'b0) begin
      n_fail++;
      $display("FAIL vid_issue: got addr %h we %b want addr 0010 we 0", MEM_ADDR, MEM_WE);
    end
    step();
    n_checks++;
    if (VID_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL vid_early_rvalid: got %b want 0", VID_RVALID);
    end
    step();
    n_checks++;
    if (VID_RVALID !== 1'b1 || VID_RDATA !== 12'hABC) begin
      n_fail++;
      $display("FAIL vid_rdata: got v=%b d=%h want v=1 d=abc", VID_RVALID, VID_RDATA);
    end
    step();
    n_checks++;
    if (VID_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL vid_rvalid_pulse: got %b want 0", VID_RVALID);
    end
  endtask

  task automatic test_cpu_wr_rd();
    repeat (3) step();
    CPU_REQ   = 1'b1;
    CPU_WE    = 1'b1;
    CPU_ADDR  = 15'h0020;
    CPU_WDATA = 12'h123;
    step();
    n_checks++;
    if (CPU_ACK !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== 15'h0020 || MEM_WDATA !== 12'h123) begin
      n_fail++;
      $display("FAIL cpu_write_issue: got ack=%b we=%b a=%h d=%h want 1 1 0020 123",
               CPU_ACK, MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    ref_mem[15'h0020] = 12'h123;
    CPU_WE = 1'b0;
    step();
    n_checks++;
    if (CPU_ACK !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 15'h0020) begin
      n_fail++;
      $display("FAIL cpu_read_issue: got ack=%b we=%b a=%h want 1 0 0020", CPU_ACK, MEM_WE, MEM_ADDR);
    end
    CPU_REQ = 1'b0;
    step();
    n_checks++;
    if (CPU_ACK !== 1'b0 || CPU_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_write_no_rvalid: got ack=%b rv=%b want 0 0", CPU_ACK, CPU_RVALID);
    end
    step();
    n_checks++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 12'h123) begin
      n_fail++;
      $display("FAIL cpu_rdata: got v=%b d=%h want v=1 d=123", CPU_RVALID, CPU_RDATA);
    end
  endtask

  task automatic test_collision();
    repeat (3) step();
    VID_REQ  = 1'b1;
    VID_ADDR = 15'h0010;
    CPU_REQ  = 1'b1;
    CPU_WE   = 1'b0;
    CPU_ADDR = 15'h0020;
    step();
    VID_REQ = 1'b0;
    n_checks++;
    if (CPU_ACK !== 1'b0 || MEM_ADDR !== 15'h0010) begin
      n_fail++;
      $display("FAIL collision_vid_first: got ack=%b a=%h want 0 0010", CPU_ACK, MEM_ADDR);
    end
    step();
    n_checks++;
    if (CPU_ACK !== 1'b1 || MEM_ADDR !== 15'h0020) begin
      n_fail++;
      $display("FAIL collision_cpu_second: got ack=%b a=%h want 1 0020", CPU_ACK, MEM_ADDR);
    end
    CPU_REQ = 1'b0;
    step();
    n_checks++;
    if (VID_RVALID !== 1'b1 || VID_RDATA !== 12'hABC) begin
      n_fail++;
      $display("FAIL collision_vid_data: got v=%b d=%h want 1 abc", VID_RVALID, VID_RDATA);
    end
    step();
    n_checks++;
    if (CPU_RVALID !== 1'b1 || CPU_RDATA !== 12'h123) begin
      n_fail++;
      $display("FAIL collision_cpu_data: got v=%b d=%h want 1 123", CPU_RVALID, CPU_RDATA);
    end
  endtask

  task automatic test_traffic(input int ncyc, input bit every2);
    logic          prev_vid, prev_cpu, prev_we;
    logic [AW-1:0] prev_vaddr, prev_caddr;
    logic [DW-1:0] prev_wdata;
    logic          issue_vid, issue_cpu, maddr_known;
    logic [AW-1:0] exp_maddr;
    logic          exp_vv [4];
    logic          exp_cv [4];
    logic [DW-1:0] exp_vd [4];
    logic [DW-1:0] exp_cd [4];
    int            last_vid, vid_tx, vid_rx;
    bit            stim;
    repeat (4) step();
    prev_vid = 1'b0; prev_cpu = 1'b0; prev_we = 1'b0;
    prev_vaddr = '0; prev_caddr = '0; prev_wdata = '0;
    maddr_known = 1'b0; exp_maddr = '0;
    last_vid = -10; vid_tx = 0; vid_rx = 0;
    for (int i = 0; i < 4; i++) begin
      exp_vv[i] = 1'b0; exp_cv[i] = 1'b0; exp_vd[i] = '0; exp_cd[i] = '0;
    end
    for (int t = 0; t < ncyc; t++) begin
      step();
      // Inputs of the previous cycle decide the slot on MEM_* now; video always wins.
      issue_vid = prev_vid;
      issue_cpu = !prev_vid && prev_cpu;
      if (issue_vid) begin
        exp_maddr = prev_vaddr;
        maddr_known = 1'b1;
        exp_vv[(t + 2) % 4] = 1'b1;
        exp_vd[(t + 2) % 4] = ref_mem[prev_vaddr];
        vid_tx++;
      end else if (issue_cpu) begin
        exp_maddr = prev_caddr;
        maddr_known = 1'b1;
        if (prev_we) begin
          ref_mem[prev_caddr] = prev_wdata;
        end else begin
          exp_cv[(t + 2) % 4] = 1'b1;
          exp_cd[(t + 2) % 4] = ref_mem[prev_caddr];
        end
      end
      n_checks++;
      if (CPU_ACK !== issue_cpu) begin
        n_fail++;
        $display("FAIL traffic_ack t=%0d: got %b want %b", t, CPU_ACK, issue_cpu);
      end
      n_checks++;
      if (MEM_WE !== (issue_cpu && prev_we)) begin
        n_fail++;
        $display("FAIL traffic_mem_we t=%0d: got %b want %b", t, MEM_WE, issue_cpu && prev_we);
      end
      if (maddr_known) begin
        n_checks++;
        if (MEM_ADDR !== exp_maddr) begin
          n_fail++;
          $display("FAIL traffic_mem_addr t=%0d: got %h want %h", t, MEM_ADDR, exp_maddr);
        end
      end
      if (issue_cpu && prev_we) begin
        n_checks++;
        if (MEM_WDATA !== prev_wdata) begin
          n_fail++;
          $display("FAIL traffic_mem_wdata t=%0d: got %h want %h", t, MEM_WDATA, prev_wdata);
        end
      end
      if (VID_RVALID === 1'b1) vid_rx++;
      n_checks++;
      if (VID_RVALID !== exp_vv[t % 4] || (exp_vv[t % 4] && VID_RDATA !== exp_vd[t % 4])) begin
        n_fail++;
        $display("FAIL traffic_vid t=%0d: got v=%b d=%h want v=%b d=%h",
                 t, VID_RVALID, VID_RDATA, exp_vv[t % 4], exp_vd[t % 4]);
      end
      n_checks++;
      if (CPU_RVALID !== exp_cv[t % 4] || (exp_cv[t % 4] && CPU_RDATA !== exp_cd[t % 4])) begin
        n_fail++;
        $display("FAIL traffic_cpu t=%0d: got v=%b d=%h want v=%b d=%h",
                 t, CPU_RVALID, CPU_RDATA, exp_cv[t % 4], exp_cd[t % 4]);
      end
      n_checks++;
      if (VID_OVERRUN !== 1'b0) begin
        n_fail++;
        $display("FAIL traffic_overrun t=%0d: got %b want 0", t, VID_OVERRUN);
      end
      exp_vv[t % 4] = 1'b0;
      exp_cv[t % 4] = 1'b0;

      stim = (t < ncyc - 4);
      if (every2) VID_REQ = stim && (t % 2 == 0);
      else VID_REQ = stim && (t - last_vid >= 2) && ($urandom_range(0, 1) == 1);
      if (VID_REQ) last_vid = t;
      VID_ADDR = AW'($urandom_range(0, 63));
      if (issue_cpu || !prev_cpu) begin
        CPU_REQ   = stim && (every2 || ($urandom_range(0, 2) != 0));
        CPU_WE    = ($urandom_range(0, 1) == 1);
        CPU_ADDR  = AW'($urandom_range(0, 63));
        CPU_WDATA = DW'($urandom);
      end
      prev_vid   = VID_REQ;
      prev_vaddr = VID_ADDR;
      prev_cpu   = CPU_REQ;
      prev_we    = CPU_WE;
      prev_caddr = CPU_ADDR;
      prev_wdata = CPU_WDATA;
    end
    idle_inputs();
    n_checks++;
    if (vid_rx !== vid_tx) begin
      n_fail++;
      $display("FAIL traffic_vid_count: got %0d returns want %0d", vid_rx, vid_tx);
    end
  endtask

`ifdef VRAM_ANTISTARVE_EN
  task automatic test_antistarve();
    repeat (3) step();
    VID_REQ  = 1'b1;
    VID_ADDR = 15'h0010;
    CPU_REQ  = 1'b1;
    CPU_WE   = 1'b0;
    CPU_ADDR = 15'h0020;
    step();
    VID_REQ = 1'b0;
    step();
    n_checks++;
    if (CPU_ACK !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_first_ack: got %b want 1", CPU_ACK);
    end
    VID_REQ  = 1'b1;
    CPU_ADDR = 15'h0030;
    step();
    n_checks++;
    if (CPU_ACK !== 1'b1 || MEM_ADDR !== 15'h0030) begin
      n_fail++;
      $display("FAIL starve_forced_slot: got ack=%b a=%h want 1 0030", CPU_ACK, MEM_ADDR);
    end
    CPU_REQ = 1'b0;
    step();
    VID_REQ = 1'b0;
    n_checks++;
    if (CPU_ACK !== 1'b0 || MEM_ADDR !== 15'h0010 || VID_OVERRUN !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_skid_issue: got ack=%b a=%h ovr=%b want 0 0010 1", CPU_ACK, MEM_ADDR, VID_OVERRUN);
    end
    step();
    n_checks++;
    if (VID_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_lat4_early: got %b want 0", VID_RVALID);
    end
    step();
    n_checks++;
    if (VID_RVALID !== 1'b1 || VID_RDATA !== 12'hABC) begin
      n_fail++;
      $display("FAIL starve_lat4_data: got v=%b d=%h want 1 abc", VID_RVALID, VID_RDATA);
    end
    step();
    n_checks++;
    if (VID_RVALID !== 1'b0 || VID_OVERRUN !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got v=%b ovr=%b want 0 1", VID_RVALID, VID_OVERRUN);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_checks++;
    if (VID_OVERRUN !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want 0", VID_OVERRUN);
    end
  endtask
`endif

  task automatic test_reset_inflight();
    logic [63:0] all_out;
    repeat (4) step();
    VID_REQ  = 1'b1;
    VID_ADDR = 15'h0010;
    step();
    VID_REQ = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    all_out = {VID_RVALID, VID_RDATA, CPU_ACK, CPU_RVALID, CPU_RDATA, MEM_ADDR, MEM_WE, MEM_WDATA, VID_OVERRUN};
    n_checks++;
    if (all_out !== 64'd0) begin
      n_fail++;
      $display("FAIL inflight_reset_outputs: got %h want 0", all_out);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (VID_RVALID !== 1'b0 || CPU_RVALID !== 1'b0) begin
        n_fail++;
        $display("FAIL inflight_dropped c=%0d: got vid=%b cpu=%b want 0 0", i, VID_RVALID, CPU_RVALID);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_vid_read();
    test_cpu_wr_rd();
    test_collision();
`ifdef VRAM_ANTISTARVE_EN
    test_antistarve();
`else
    test_traffic(24, 1'b1);
    test_traffic(300, 1'b0);
`endif
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
